sum_sequencer: RTL and testbench

SUM_SEQUENCER -- requirements
Module: sum_sequencer

---
 rtl/sum_seq_pkg.sv | 26 ++
 rtl/bcd_check.sv | 28 ++
 rtl/sum_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_sum_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : sum_seq_pkg
// Brief  : Shared types and constants for the sum_sequencer block:
//          FSM state encoding, BCD field widths and the display error code.
// Rev    : 1.0  initial release
// ============================================================================
package sum_seq_pkg;

    localparam int NUM_W   = 12;   // 3-digit BCD operand
    localparam int SUM_W   = 16;   // 4-digit BCD sum / display word
    localparam int DIGIT_W = 4;    // one BCD digit

    localparam logic [SUM_W-1:0] DISP_ERR = 16'hEEEE;

    typedef enum logic [2:0] {
        WAIT_A    = 3'd0,
        WAIT_B    = 3'd1,
        START_ADD = 3'd2,
        WAIT_SUM  = 3'd3,
        SHOW      = 3'd4,
        ERROR     = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bcd_check.sv
`default_nettype none
// ============================================================================
// Module : bcd_check
// Brief  : Combinational BCD validity test. valid_o is high only when every
//          4-bit digit of num_i lies in 0..9.
// Ports  : num_i   [NUM_W-1:0]  candidate BCD number
//          valid_o              1 = all digits legal
// Rev    : 1.0  initial release
// ============================================================================
module bcd_check
    import sum_seq_pkg::*;
(
    input  logic [NUM_W-1:0] num_i,
    output logic             valid_o
);

    localparam int C_DIGITS = NUM_W / DIGIT_W;

    logic [C_DIGITS-1:0] w_digit_ok;

    for (genvar d = 0; d < C_DIGITS; d++) begin : g_digit
        assign w_digit_ok[d] = (num_i[d*DIGIT_W +: DIGIT_W] <= 4'd9);
    end

    assign valid_o = &w_digit_ok;

endmodule
`default_nettype wire

// File: rtl/sum_sequencer.sv
`default_nettype none
// ============================================================================
// Module : sum_sequencer
// Brief  : Sequences a two-operand BCD addition: collects operand A and B
//          from the input manager, kicks an external BCD adder, captures its
//          sum and drives the display. No arithmetic is done here.
// Config : SUM_SEQ_TIMEOUT_EN - when defined, a watchdog limits the wait for
//          add_done to TIMEOUT_CYCLES cycles and enters ERROR on expiry.
// Ports  : clk, reset            clock, synchronous active-high reset
//          num_in, num_valid     BCD number from input manager
//          clear                 user clear pulse
//          im_clear              restart digit entry in input manager
//          op_a, op_b            registered BCD operands
//          add_start             adder start pulse
//          add_done, add_sum     adder completion strobe and sum
//          disp_value            registered display word
//          result_valid          high while a captured sum is shown
//          state_o               current FSM state
//          bcd_err               pulse when num_in is rejected
//          timeout_err           high while in ERROR
// Rev    : 1.0  initial release
// ============================================================================
module sum_sequencer
    import sum_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_W-1:0] num_in,
    input  logic             num_valid,
    input  logic             clear,
    output logic             im_clear,
    output logic [NUM_W-1:0] op_a,
    output logic [NUM_W-1:0] op_b,
    output logic             add_start,
    input  logic             add_done,
    input  logic [SUM_W-1:0] add_sum,
    output logic [SUM_W-1:0] disp_value,
    output logic             result_valid,
    output logic [2:0]       state_o,
    output logic             bcd_err,
    output logic             timeout_err
);

    localparam int C_PAD_W = SUM_W - NUM_W;

    state_e           state_q;
    logic [NUM_W-1:0] op_a_q;
    logic [NUM_W-1:0] op_b_q;
    logic [SUM_W-1:0] result_q;
    logic [SUM_W-1:0] disp_q;
    logic             im_clear_q;
    logic             add_start_q;
    logic             bcd_err_q;
    logic             result_valid_q;
    logic             w_num_ok;

    bcd_check u_bcd_check (
        .num_i   (num_in),
        .valid_o (w_num_ok)
    );

`ifdef SUM_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             timeout_err_q;
`else
    // Watchdog is not built; keep the parameter referenced.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WAIT_A;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_q       <= '0;
            disp_q         <= '0;
            im_clear_q     <= 1'b0;
            add_start_q    <= 1'b0;
            bcd_err_q      <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef SUM_SEQ_TIMEOUT_EN
            wd_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            im_clear_q  <= 1'b0;
            add_start_q <= 1'b0;
            bcd_err_q   <= 1'b0;

            // Display follows the state of the previous cycle, so it lags
            // every state change by exactly one clock.
            case (state_q)
                WAIT_A:             disp_q <= '0;
                WAIT_B:             disp_q <= {{C_PAD_W{1'b0}}, op_a_q};
                START_ADD, WAIT_SUM: disp_q <= {{C_PAD_W{1'b0}}, op_b_q};
                SHOW:               disp_q <= result_q;
                ERROR:              disp_q <= DISP_ERR;
                default:            disp_q <= '0;
            endcase

            if (clear) begin
                // Clear overrides every other event, including num_valid.
                state_q        <= WAIT_A;
                op_a_q         <= '0;
                op_b_q         <= '0;
                result_q       <= '0;
                im_clear_q     <= 1'b1;
                result_valid_q <= 1'b0;
`ifdef SUM_SEQ_TIMEOUT_EN
                wd_cnt_q       <= '0;
                timeout_err_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    WAIT_A: begin
                        if (num_valid) begin
                            if (w_num_ok) begin
                                op_a_q     <= num_in;
                                im_clear_q <= 1'b1;
                                state_q    <= WAIT_B;
                            end else begin
                                bcd_err_q  <= 1'b1;
                            end
                        end
                    end
                    WAIT_B: begin
                        if (num_valid) begin
                            if (w_num_ok) begin
                                op_b_q      <= num_in;
                                im_clear_q  <= 1'b1;
                                add_start_q <= 1'b1;   // high for the START_ADD cycle
                                state_q     <= START_ADD;
                            end else begin
                                bcd_err_q   <= 1'b1;
                            end
                        end
                    end
                    START_ADD: begin
                        state_q  <= WAIT_SUM;
`ifdef SUM_SEQ_TIMEOUT_EN
                        wd_cnt_q <= '0;
`endif
                    end
                    WAIT_SUM: begin
                        if (add_done) begin
                            result_q       <= add_sum;
                            result_valid_q <= 1'b1;
                            state_q        <= SHOW;
`ifdef SUM_SEQ_TIMEOUT_EN
                        end else if (wd_cnt_q == C_CNT_LAST) begin
                            // Limit reached; add_done in this cycle would
                            // have taken the branch above instead.
                            timeout_err_q  <= 1'b1;
                            state_q        <= ERROR;
                        end else begin
                            wd_cnt_q       <= wd_cnt_q + CNT_W'(1);
`endif
                        end
                    end
                    SHOW: begin
                        if (num_valid) begin
                            if (w_num_ok) begin
                                op_a_q         <= num_in;
                                im_clear_q     <= 1'b1;
                                result_valid_q <= 1'b0;
                                state_q        <= WAIT_B;
                            end else begin
                                bcd_err_q      <= 1'b1;
                            end
                        end
                    end
                    ERROR: begin
                        // Only clear or reset leaves ERROR.
                    end
                    default: begin
                        state_q <= WAIT_A;
                    end
                endcase
            end
        end
    end

    assign im_clear     = im_clear_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign add_start    = add_start_q;
    assign disp_value   = disp_q;
    assign result_valid = result_valid_q;
    assign state_o      = state_q;
    assign bcd_err      = bcd_err_q;
`ifdef SUM_SEQ_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_sum_sequencer
// Brief  : Directed self-checking bench for sum_sequencer. Inputs change 1
//          time unit after a rising edge; outputs are sampled at that point.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sum_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] num_in;
    logic        num_valid;
    logic        clear;
    logic        im_clear;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        add_start;
    logic        add_done;
    logic [15:0] add_sum;
    logic [15:0] disp_value;
    logic        result_valid;
    logic [2:0]  state_o;
    logic        bcd_err;
    logic        timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    sum_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .num_in       (num_in),
        .num_valid    (num_valid),
        .clear        (clear),
        .im_clear     (im_clear),
        .op_a         (op_a),
        .op_b         (op_b),
        .add_start    (add_start),
        .add_done     (add_done),
        .add_sum      (add_sum),
        .disp_value   (disp_value),
        .result_valid (result_valid),
        .state_o      (state_o),
        .bcd_err      (bcd_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_num(input logic [11:0] v);
        num_in    = v;
        num_valid = 1'b1;
        tick();
        num_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] s);
        add_sum  = s;
        add_done = 1'b1;
        tick();
        add_done = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; num_valid = 1'b1; num_in = 12'h123; add_done = 1'b1; add_sum = 16'h0579; clear = 1'b0;
        tick(); tick();
        num_valid = 1'b0; add_done = 1'b0;
        n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state_o); end
        n_cmp++; if (op_a !== 12'h000 || op_b !== 12'h000) begin n_fail++; $display("FAIL rst_ops got %h/%h want 000/000", op_a, op_b); end
        n_cmp++; if (disp_value !== 16'h0000) begin n_fail++; $display("FAIL rst_disp got %h want 0000", disp_value); end
        n_cmp++; if ({im_clear, add_start, result_valid, bcd_err, timeout_err} !== 5'b0) begin n_fail++;
            $display("FAIL rst_strobes got %b want 00000", {im_clear, add_start, result_valid, bcd_err, timeout_err}); end
        reset = 1'b0;
        tick();
        n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rst_idle got %0d want 0", state_o); end
    endtask

    task automatic test_basic_sum();
        drive_num(12'h123);
        n_cmp++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL sum_a_state got %0d want 1", state_o); end
        n_cmp++; if (op_a !== 12'h123) begin n_fail++; $display("FAIL sum_op_a got %h want 123", op_a); end
        n_cmp++; if (im_clear !== 1'b1) begin n_fail++; $display("FAIL sum_imclr_a got %b want 1", im_clear); end
        drive_num(12'h456);
        n_cmp++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL sum_b_state got %0d want 2", state_o); end
        n_cmp++; if (op_b !== 12'h456) begin n_fail++; $display("FAIL sum_op_b got %h want 456", op_b); end
        n_cmp++; if (add_start !== 1'b1) begin n_fail++; $display("FAIL sum_start_hi got %b want 1", add_start); end
        n_cmp++; if (disp_value !== 16'h0123) begin n_fail++; $display("FAIL sum_disp_a got %h want 0123", disp_value); end
        tick();
        n_cmp++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL sum_wait_state got %0d want 3", state_o); end
        n_cmp++; if (add_start !== 1'b0) begin n_fail++; $display("FAIL sum_start_lo got %b want 0", add_start); end
        n_cmp++; if (disp_value !== 16'h0456) begin n_fail++; $display("FAIL sum_disp_b got %h want 0456", disp_value); end
        pulse_done(16'h0579);
        n_cmp++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL sum_show_state got %0d want 4", state_o); end
        n_cmp++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL sum_rv got %b want 1", result_valid); end
        tick();
        n_cmp++; if (disp_value !== 16'h0579) begin n_fail++; $display("FAIL sum_disp_res got %h want 0579", disp_value); end
    endtask

    task automatic test_show_restart();
        drive_num(12'h999);
        n_cmp++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL show_state got %0d want 1", state_o); end
        n_cmp++; if (op_a !== 12'h999) begin n_fail++; $display("FAIL show_op_a got %h want 999", op_a); end
        n_cmp++; if (result_valid !== 1'b0 || im_clear !== 1'b1) begin n_fail++;
            $display("FAIL show_rv_imclr got %b%b want 01", result_valid, im_clear); end
        drive_num(12'h999);
        tick();
        pulse_done(16'h1998);
        tick();
        n_cmp++; if (disp_value !== 16'h1998) begin n_fail++; $display("FAIL show_disp_max got %h want 1998", disp_value); end
        n_cmp++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL show_state2 got %0d want 4", state_o); end
    endtask

    task automatic test_clear_priority();
        drive_num(12'h321);   // SHOW -> WAIT_B with op_b still 999
        n_cmp++; if (op_b !== 12'h999) begin n_fail++; $display("FAIL clr_pre_op_b got %h want 999", op_b); end
        clear = 1'b1; num_valid = 1'b1; num_in = 12'h999;
        tick();
        clear = 1'b0; num_valid = 1'b0;
        n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL clr_state got %0d want 0", state_o); end
        n_cmp++; if (op_b !== 12'h000 || op_a !== 12'h000) begin n_fail++; $display("FAIL clr_ops got %h/%h want 000/000", op_a, op_b); end
        n_cmp++; if (im_clear !== 1'b1) begin n_fail++; $display("FAIL clr_imclr got %b want 1", im_clear); end
        tick();
        n_cmp++; if (im_clear !== 1'b0 || disp_value !== 16'h0000) begin n_fail++;
            $display("FAIL clr_after got imclr=%b disp=%h want 0/0000", im_clear, disp_value); end
    endtask

    task automatic test_bcd_reject();
        drive_num(12'h1A3);
        n_cmp++; if (bcd_err !== 1'b1) begin n_fail++; $display("FAIL bcd_err_a got %b want 1", bcd_err); end
        n_cmp++; if (state_o !== 3'd0 || op_a !== 12'h000) begin n_fail++;
            $display("FAIL bcd_hold_a got state=%0d op_a=%h want 0/000", state_o, op_a); end
        tick();
        n_cmp++; if (bcd_err !== 1'b0) begin n_fail++; $display("FAIL bcd_err_pulse got %b want 0", bcd_err); end
        drive_num(12'h900);
        drive_num(12'h0A0);
        n_cmp++; if (bcd_err !== 1'b1 || state_o !== 3'd1 || op_b !== 12'h000) begin n_fail++;
            $display("FAIL bcd_err_b got err=%b state=%0d op_b=%h want 1/1/000", bcd_err, state_o, op_b); end
        drive_num(12'hF09);
        n_cmp++; if (bcd_err !== 1'b1 || state_o !== 3'd1) begin n_fail++;
            $display("FAIL bcd_err_hi got err=%b state=%0d want 1/1", bcd_err, state_o); end
        do_clear();
    endtask

    task automatic test_ignored_events();
        pulse_done(16'h1234);
        n_cmp++; if (state_o !== 3'd0 || result_valid !== 1'b0) begin n_fail++;
            $display("FAIL ign_done got state=%0d rv=%b want 0/0", state_o, result_valid); end
        drive_num(12'h005);
        drive_num(12'h009);
        drive_num(12'h777);   // in START_ADD, must be ignored
        n_cmp++; if (state_o !== 3'd3 || op_a !== 12'h005) begin n_fail++;
            $display("FAIL ign_start got state=%0d op_a=%h want 3/005", state_o, op_a); end
        drive_num(12'h888);   // in WAIT_SUM, must be ignored
        n_cmp++; if (state_o !== 3'd3 || op_a !== 12'h005 || im_clear !== 1'b0) begin n_fail++;
            $display("FAIL ign_wait got state=%0d op_a=%h imclr=%b want 3/005/0", state_o, op_a, im_clear); end
        pulse_done(16'h0014);
        tick();
        n_cmp++; if (disp_value !== 16'h0014) begin n_fail++; $display("FAIL ign_sum got %h want 0014", disp_value); end
        do_clear();
    endtask

    task automatic test_timeout();
        drive_num(12'h001);
        drive_num(12'h002);
        tick();               // now in WAIT_SUM, watchdog at 0
`ifdef SUM_SEQ_TIMEOUT_EN
        repeat (7) tick();
        n_cmp++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL to_pre got %0d want 3", state_o); end
        tick();
        n_cmp++; if (state_o !== 3'd5 || timeout_err !== 1'b1) begin n_fail++;
            $display("FAIL to_err got state=%0d terr=%b want 5/1", state_o, timeout_err); end
        tick();
        n_cmp++; if (disp_value !== 16'hEEEE) begin n_fail++; $display("FAIL to_disp got %h want EEEE", disp_value); end
        drive_num(12'h111);
        pulse_done(16'h0003);
        n_cmp++; if (state_o !== 3'd5 || timeout_err !== 1'b1) begin n_fail++;
            $display("FAIL to_sticky got state=%0d terr=%b want 5/1", state_o, timeout_err); end
        do_clear();
        n_cmp++; if (state_o !== 3'd0 || timeout_err !== 1'b0) begin n_fail++;
            $display("FAIL to_clear got state=%0d terr=%b want 0/0", state_o, timeout_err); end
        drive_num(12'h001);
        drive_num(12'h002);
        tick();
        repeat (7) tick();
        pulse_done(16'h0003);   // arrives in the limit cycle and must win
        n_cmp++; if (state_o !== 3'd4 || timeout_err !== 1'b0) begin n_fail++;
            $display("FAIL to_limit_win got state=%0d terr=%b want 4/0", state_o, timeout_err); end
`else
        repeat (40) tick();
        n_cmp++; if (state_o !== 3'd3 || timeout_err !== 1'b0) begin n_fail++;
            $display("FAIL nowd_wait got state=%0d terr=%b want 3/0", state_o, timeout_err); end
        pulse_done(16'h0003);
        n_cmp++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL nowd_done got %0d want 4", state_o); end
`endif
        do_clear();
    endtask

    task automatic test_reset_midop();
        drive_num(12'h050);
        drive_num(12'h060);
        tick();
        n_cmp++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL mid_pre got %0d want 3", state_o); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (state_o !== 3'd0 || op_a !== 12'h000 || op_b !== 12'h000 || disp_value !== 16'h0000) begin n_fail++;
            $display("FAIL mid_rst got state=%0d op_a=%h op_b=%h disp=%h want 0/000/000/0000", state_o, op_a, op_b, disp_value); end
        n_cmp++; if ({im_clear, add_start, result_valid, bcd_err, timeout_err} !== 5'b0) begin n_fail++;
            $display("FAIL mid_strobes got %b want 00000", {im_clear, add_start, result_valid, bcd_err, timeout_err}); end
        pulse_done(16'h0110);
        tick();
        n_cmp++; if (state_o !== 3'd0 || result_valid !== 1'b0 || disp_value !== 16'h0000) begin n_fail++;
            $display("FAIL mid_done got state=%0d rv=%b disp=%h want 0/0/0000", state_o, result_valid, disp_value); end
    endtask

    initial begin
        reset = 1'b1; num_in = '0; num_valid = 1'b0; clear = 1'b0; add_done = 1'b0; add_sum = '0;
        test_reset();
        test_basic_sum();
        test_show_restart();
        test_clear_priority();
        test_bcd_reject();
        test_ignored_events();
        test_timeout();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
